// File: rtl/audio_vis_pkg.sv
// Shared types, defaults and arithmetic helpers for the audio visualiser bar path.
// DECAY_STEP_DEF and MAX_HEIGHT_DEF are also consumed by the pixel generator.
package audio_vis_pkg;

    localparam int SAMPLE_W_DEF   = 16;
    localparam int HEIGHT_W_DEF   = 9;
    localparam int MAX_HEIGHT_DEF = 479;
    localparam int DECAY_STEP_DEF = 4;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;
    typedef logic        [HEIGHT_W_DEF-1:0] height_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        COMMIT = 1'b1
    } state_t;

    // Magnitude of a w-bit sample (sign-extended to 32 bits); -2^(w-1) saturates to 2^(w-1)-1.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] s, input int w);
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (w - 1)) - 32'd1;
        mag = s[31] ? $unsigned(-s) : $unsigned(s);
        sat_abs = (mag > lim) ? lim : mag;
    endfunction

    // Drop the low magnitude bits to reach bar resolution, then clamp to the screen height.
    function automatic logic [31:0] scale_height(input logic [31:0] acc, input int shift,
                                                 input int max_h);
        logic [31:0] h;
        h = (shift > 0) ? (acc >> shift) : acc;
        scale_height = (h > 32'(max_h)) ? 32'(max_h) : h;
    endfunction

endpackage

// File: rtl/bar_decay_unit.sv
// Next-height logic for the bar being committed: new peaks jump up immediately,
// otherwise the bar falls by at most DECAY_STEP without wrapping below zero.
module bar_decay_unit
    import audio_vis_pkg::*;
#(
    parameter int HEIGHT_W   = HEIGHT_W_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic [HEIGHT_W-1:0] h_new_i,
    input  logic [HEIGHT_W-1:0] h_cur_i,
    output logic [HEIGHT_W-1:0] h_next_o
);

    logic [HEIGHT_W-1:0] decayed_s;

    // Saturating fall-off, then keep whichever of (fresh, decayed) is taller.
    always_comb begin
        if (h_cur_i > HEIGHT_W'(DECAY_STEP)) begin
            decayed_s = h_cur_i - HEIGHT_W'(DECAY_STEP);
        end else begin
            decayed_s = '0;
        end
        if (h_new_i >= h_cur_i) begin
            h_next_o = h_new_i;
        end else if (h_new_i > decayed_s) begin
            h_next_o = h_new_i;
        end else begin
            h_next_o = decayed_s;
        end
    end

endmodule

// File: rtl/audio_bar_tracker.sv
// Reduces the PCM sample stream to NUM_BARS decaying bar heights with a tear-free display copy.
// Optional PEAK_HOLD_EN adds per-bar peak markers with a HOLD_FRAMES hold time.
module audio_bar_tracker
    import audio_vis_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int NUM_BARS    = 32,
    parameter int WINDOW_LOG2 = 8,
    parameter int HEIGHT_W    = HEIGHT_W_DEF,
    parameter int MAX_HEIGHT  = MAX_HEIGHT_DEF,
    parameter int DECAY_STEP  = DECAY_STEP_DEF,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    input  logic signed [SAMPLE_W-1:0]  sample_data,
    input  logic                        frame_start,
    input  logic [$clog2(NUM_BARS)-1:0] rd_bar_idx,
    output logic [HEIGHT_W-1:0]         rd_height,
    output logic [HEIGHT_W-1:0]         rd_peak,
    output logic                        round_done
);

    localparam int IDX_W = $clog2(NUM_BARS);

    state_t               state_q, state_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]     bar_q, bar_d;
    logic [HEIGHT_W-1:0]  working_q [NUM_BARS];
    logic [HEIGHT_W-1:0]  display_q [NUM_BARS];
    logic [HEIGHT_W-1:0]  rd_height_q, rd_peak_q;

    logic signed [31:0]   sample_ext_s;
    logic [SAMPLE_W-1:0]  mag_s;
    logic [HEIGHT_W-1:0]  h_new_s, h_next_s;
    logic                 commit_s, ready_s;

    assign sample_ext_s = {{(32-SAMPLE_W){sample_data[SAMPLE_W-1]}}, sample_data};
    assign mag_s        = SAMPLE_W'(sat_abs(sample_ext_s, SAMPLE_W));
    assign h_new_s      = HEIGHT_W'(scale_height(32'(acc_q), SAMPLE_W - 1 - HEIGHT_W, MAX_HEIGHT));

    bar_decay_unit #(
        .HEIGHT_W   (HEIGHT_W),
        .DECAY_STEP (DECAY_STEP)
    ) u_decay (
        .h_new_i  (h_new_s),
        .h_cur_i  (working_q[bar_q]),
        .h_next_o (h_next_s)
    );

    // Window accumulation and bar sequencing state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            bar_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bar_q   <= bar_d;
        end
    end

    // ACCUM folds each accepted sample into a running peak; COMMIT is a one-cycle stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        bar_d    = bar_q;
        ready_s  = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            ACCUM: begin
                ready_s = 1'b1;
                if (sample_valid) begin
                    acc_d = (mag_s > acc_q) ? mag_s : acc_q;
                    cnt_d = cnt_q + WINDOW_LOG2'(1);
                    if (cnt_q == {WINDOW_LOG2{1'b1}}) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                acc_d    = '0;
                bar_d    = bar_q + IDX_W'(1);
                state_d  = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign sample_ready = ready_s;
    assign round_done   = commit_s && (bar_q == IDX_W'(NUM_BARS - 1));

    // Working heights change only on commit; display snapshots them on frame_start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                working_q[i] <= '0;
                display_q[i] <= '0;
            end
        end else begin
            if (commit_s) begin
                working_q[bar_q] <= h_next_s;
            end
            if (frame_start) begin
                for (int i = 0; i < NUM_BARS; i++) begin
                    display_q[i] <= working_q[i];
                end
            end
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [HEIGHT_W-1:0] peak_q [NUM_BARS];
    logic [HOLD_W-1:0]   hold_q [NUM_BARS];

    // Peak markers follow the value being displayed; peak stays >= working so a plain decrement suffices.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                peak_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                if (working_q[i] >= peak_q[i]) begin
                    peak_q[i] <= working_q[i];
                    hold_q[i] <= HOLD_W'(HOLD_FRAMES);
                end else if (hold_q[i] != '0) begin
                    hold_q[i] <= hold_q[i] - HOLD_W'(1);
                end else begin
                    peak_q[i] <= peak_q[i] - HEIGHT_W'(1);
                end
            end
        end
    end
`endif

    // Registered read port for the pixel generator.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_height_q <= '0;
            rd_peak_q   <= '0;
        end else begin
            rd_height_q <= display_q[rd_bar_idx];
`ifdef PEAK_HOLD_EN
            rd_peak_q   <= peak_q[rd_bar_idx];
`else
            rd_peak_q   <= display_q[rd_bar_idx];
`endif
        end
    end

    assign rd_height = rd_height_q;
    assign rd_peak   = rd_peak_q;

endmodule
